// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states and
// the Booth pair encodings {multiplier lsb, q-1}.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] PAIR_NOP_LO = 2'b00;
    localparam logic [1:0] PAIR_ADD    = 2'b01;
    localparam logic [1:0] PAIR_SUB    = 2'b10;
    localparam logic [1:0] PAIR_NOP_HI = 2'b11;

endpackage

// File: rtl/seq_booth_multiplier_if.sv
// Request/response bundle of the sequential Booth multiplier.
interface seq_booth_multiplier_if #(
    parameter int unsigned WIDTH = 8
);

    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );

endinterface

// File: rtl/booth_step.sv
// One combinational Booth iteration: add/subtract the multiplicand according
// to the current pair, then arithmetic-shift {acc, mq, q1} right by one.
module booth_step
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH+1:0] acc,
    input  logic [WIDTH:0]   mq,
    input  logic             q1,
    input  logic [WIDTH:0]   mcand,
    output logic [WIDTH+1:0] acc_c,
    output logic [WIDTH:0]   mq_c,
    output logic             q1_c
);

    logic [WIDTH+1:0] mcand_wide;
    logic [WIDTH+1:0] sum;

    // Guard bit keeps -(most negative extended operand) representable
    assign mcand_wide = {mcand[WIDTH], mcand};

    always_comb begin
        sum = acc;
        case ({mq[0], q1})
            PAIR_SUB: sum = acc - mcand_wide;
            PAIR_ADD: sum = acc + mcand_wide;
            default:  sum = acc;
        endcase
    end

    assign acc_c = {sum[WIDTH+1], sum[WIDTH+1:1]};
    assign mq_c  = {sum[0], mq[WIDTH:1]};
    assign q1_c  = mq[0];

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier with fixed WIDTH+1 cycle latency,
// signed or unsigned operands selected per operation.
module seq_booth_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_booth_multiplier_if.slave bus
);

    localparam int unsigned XW = WIDTH + 1;
    localparam int unsigned AW = WIDTH + 2;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [XW-1:0]  mcand, mcand_n;
    logic [XW-1:0]  mq, mq_n;
    logic [AW-1:0]  acc, acc_n;
    logic           q1, q1_n;
    logic [PW-1:0]  product, product_n;
    logic           busy, busy_n;
    logic           done, done_n;

    logic [AW-1:0]  acc_c;
    logic [XW-1:0]  mq_c;
    logic           q1_c;
    logic [XW-1:0]  mcand_ext_c;
    logic [XW-1:0]  mplier_ext_c;

    // Sign- or zero-extend operands to WIDTH+1 so unsigned values stay positive
    assign mcand_ext_c  = {bus.signed_mode & bus.multiplicand[WIDTH-1], bus.multiplicand};
    assign mplier_ext_c = {bus.signed_mode & bus.multiplier[WIDTH-1],   bus.multiplier};

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc   (acc),
        .mq    (mq),
        .q1    (q1),
        .mcand (mcand),
        .acc_c (acc_c),
        .mq_c  (mq_c),
        .q1_c  (q1_c)
    );

    // Next-state and datapath update
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mcand_n   = mcand;
        mq_n      = mq;
        acc_n     = acc;
        q1_n      = q1;
        product_n = product;

        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (bus.start) begin
                    state_n = BUSY;
                    mcand_n = mcand_ext_c;
                    mq_n    = mplier_ext_c;
                    acc_n   = '0;
                    q1_n    = 1'b0;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                acc_n = acc_c;
                mq_n  = mq_c;
                q1_n  = q1_c;
                cnt_n = CW'(cnt + 1'b1);
                if (cnt == CW'(WIDTH)) begin
                    product_n = {acc_c[WIDTH-2:0], mq_c};
                    state_n   = DONE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == BUSY);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mq      <= '0;
            acc     <= '0;
            q1      <= 1'b0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mcand   <= mcand_n;
            mq      <= mq_n;
            acc     <= acc_n;
            q1      <= q1_n;
            product <= product_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard bench for seq_booth_multiplier at WIDTH 8, 4 and 16: directed
// WIDTH=8 cases plus a random signed/unsigned sweep on WIDTH 4 and 16.
module tb_seq_booth_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_booth_multiplier_if #(.WIDTH(8))  if8 ();
    seq_booth_multiplier_if #(.WIDTH(4))  if4 ();
    seq_booth_multiplier_if #(.WIDTH(16)) if16 ();

    seq_booth_multiplier #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
    seq_booth_multiplier #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
    seq_booth_multiplier #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));

    // Expected products and the cycle their done must appear
    logic [31:0] q8[$], q4[$], q16[$];
    int          c8[$], c4[$], c16[$];
    logic [15:0] last8 = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input int unsigned w, input bit s,
                                            input logic [31:0] a, input logic [31:0] b);
        longint m, x, y, p;
        m = (longint'(1) << w) - 1;
        x = longint'(a) & m;
        y = longint'(b) & m;
        if (s && ((x >> (w - 1)) & 1) != 0) x = x - (longint'(1) << w);
        if (s && ((y >> (w - 1)) & 1) != 0) y = y - (longint'(1) << w);
        p = x * y;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    always @(negedge clk) if (if8.done === 1'b1) begin
        check("done8_expected", {31'd0, q8.size() != 0}, 32'd1);
        check("busy8_at_done", 32'(if8.busy), 32'd0);
        if (q8.size() != 0) begin
            check("prod8", 32'(if8.product), q8.pop_front());
            check("lat8", 32'(cyc), 32'(c8.pop_front()));
        end
    end

    always @(negedge clk) if (if4.done === 1'b1) begin
        check("done4_expected", {31'd0, q4.size() != 0}, 32'd1);
        if (q4.size() != 0) begin
            check("prod4", 32'(if4.product), q4.pop_front());
            check("lat4", 32'(cyc), 32'(c4.pop_front()));
        end
    end

    always @(negedge clk) if (if16.done === 1'b1) begin
        check("done16_expected", {31'd0, q16.size() != 0}, 32'd1);
        if (q16.size() != 0) begin
            check("prod16", if16.product, q16.pop_front());
            check("lat16", 32'(cyc), 32'(c16.pop_front()));
        end
    end

    task automatic issue8(input bit s, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        if8.start        = 1'b1;
        if8.signed_mode  = s;
        if8.multiplicand = a;
        if8.multiplier   = b;
        q8.push_back(32'(exp));
        c8.push_back(cyc + 10);
    endtask

    // Drop start and scramble operands, which the DUT must ignore
    task automatic release8();
        if8.start        = 1'b0;
        if8.signed_mode  = 1'($urandom);
        if8.multiplicand = 8'($urandom);
        if8.multiplier   = 8'($urandom);
    endtask

    task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
        issue8(s, a, b, exp);
        @(negedge clk);
        release8();
        check("busy8", 32'(if8.busy), 32'd1);
        check("hold8_early", 32'(if8.product), 32'(last8));
        repeat (8) @(negedge clk);
        check("hold8_late", 32'(if8.product), 32'(last8));
        @(negedge clk);
        @(negedge clk);
        check("idle8_busy", 32'(if8.busy), 32'd0);
        check("idle8_done", 32'(if8.done), 32'd0);
        last8 = exp;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  a4, b4;
        logic [15:0] a16, b16;
        bit          s4, s16;

        if8.start = 1'b0;  if8.signed_mode = 1'b0;  if8.multiplicand = '0;  if8.multiplier = '0;
        if4.start = 1'b0;  if4.signed_mode = 1'b0;  if4.multiplicand = '0;  if4.multiplier = '0;
        if16.start = 1'b0; if16.signed_mode = 1'b0; if16.multiplicand = '0; if16.multiplier = '0;

        repeat (3) @(negedge clk);
        check("rst_busy8", 32'(if8.busy), 32'd0);
        check("rst_done8", 32'(if8.done), 32'd0);
        check("rst_prod8", 32'(if8.product), 32'd0);
        check("rst_prod16", if16.product, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Signed and extreme directed cases
        run8(1'b1, 8'h03, 8'h01, 16'h0003);
        run8(1'b1, 8'hFA, 8'h07, 16'hFFD6);
        run8(1'b1, 8'hFE, 8'hFB, 16'h000A);
        run8(1'b1, 8'hFB, 8'hFB, 16'h0019);
        run8(1'b1, 8'h80, 8'h80, 16'h4000);
        run8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run8(1'b0, 8'h80, 8'h02, 16'h0100);

        // Start re-pulsed in busy cycle 4 must be ignored
        issue8(1'b1, 8'hFA, 8'h07, 16'hFFD6);
        @(negedge clk);
        release8();
        repeat (3) @(negedge clk);
        if8.start = 1'b1; if8.signed_mode = 1'b0; if8.multiplicand = 8'd200; if8.multiplier = 8'd100;
        @(negedge clk);
        release8();
        check("ignored_busy", 32'(if8.busy), 32'd1);
        repeat (5) @(negedge clk);
        @(negedge clk);
        last8 = 16'hFFD6;
        repeat (12) @(negedge clk);

        // Back-to-back: start held during the done cycle
        issue8(1'b1, 8'h03, 8'h01, 16'h0003);
        @(negedge clk);
        release8();
        repeat (9) @(negedge clk);
        check("b2b_first_done", 32'(if8.done), 32'd1);
        issue8(1'b1, 8'hFE, 8'hFB, 16'h000A);
        @(negedge clk);
        release8();
        check("b2b_busy", 32'(if8.busy), 32'd1);
        check("b2b_hold", 32'(if8.product), 32'h0003);
        repeat (9) @(negedge clk);
        @(negedge clk);
        last8 = 16'h000A;

        // Asynchronous reset in busy cycle 5 aborts the operation
        issue8(1'b1, 8'hFA, 8'h07, 16'hFFD6);
        @(negedge clk);
        release8();
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(if8.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(if8.busy), 32'd0);
        check("abort_done", 32'(if8.done), 32'd0);
        check("abort_prod", 32'(if8.product), 32'd0);
        q8.delete();
        c8.delete();
        @(negedge clk);
        rst = 1'b0;
        last8 = 16'h0;
        repeat (15) @(negedge clk);
        check("abort_idle", 32'(if8.busy), 32'd0);
        run8(1'b1, 8'h07, 8'h07, 16'h0031);

        // WIDTH 4 and 16 sweep against the arithmetic reference
        for (int i = 0; i < 16; i++) begin
            s4  = 1'($urandom);  a4  = 4'($urandom);  b4  = 4'($urandom);
            s16 = 1'($urandom);  a16 = 16'($urandom); b16 = 16'($urandom);
            if (i == 0) begin
                s4 = 1'b1; a4 = 4'h8; b4 = 4'h8; s16 = 1'b1; a16 = 16'h8000; b16 = 16'h8000;
            end else if (i == 1) begin
                s4 = 1'b0; a4 = 4'hF; b4 = 4'hF; s16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
            end
            if4.start = 1'b1;  if4.signed_mode = s4;   if4.multiplicand = a4;   if4.multiplier = b4;
            if16.start = 1'b1; if16.signed_mode = s16; if16.multiplicand = a16; if16.multiplier = b16;
            q4.push_back(ref_mul(4, s4, 32'(a4), 32'(b4)));
            c4.push_back(cyc + 6);
            q16.push_back(ref_mul(16, s16, 32'(a16), 32'(b16)));
            c16.push_back(cyc + 18);
            @(negedge clk);
            if4.start = 1'b0;  if4.multiplicand = 4'($urandom);   if4.multiplier = 4'($urandom);
            if16.start = 1'b0; if16.multiplicand = 16'($urandom); if16.multiplier = 16'($urandom);
            repeat (18) @(negedge clk);
        end

        for (int i = 0; i < 200 && (q8.size() + q4.size() + q16.size()) != 0; i++)
            @(negedge clk);
        check("drain", 32'(q8.size() + q4.size() + q16.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_booth_multiplier.md
SEQ_BOOTH_MULTIPLIER -- requirements
Module: seq_booth_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled on rising clk edges.
REQ-005 SHALL have port signed_mode  input  1  1 = operands are two's complement, 0 = operands are unsigned; sampled with start.
REQ-006 SHALL have port multiplicand  input  WIDTH  first operand; sampled with start.
REQ-007 SHALL have port multiplier  input  WIDTH  second operand; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; product is valid from this cycle.
REQ-010 SHALL have port product  output  2*WIDTH  result; signed or unsigned per the captured signed_mode.

Function
REQ-011 SHALL implement radix-2 Booth recoding: one iteration per BUSY cycle; operand pair 10 subtracts, 01 adds, 00/11 no-op; then arithmetic right shift of the {accumulator, multiplier, q-1} register.
REQ-012 SHALL extend both operands to WIDTH+1 bits at capture: sign-extend when signed_mode=1, zero-extend when signed_mode=0.
REQ-013 SHALL always perform exactly WIDTH+1 iterations, giving a fixed latency independent of mode and operand values.
REQ-014 SHALL hold accumulator arithmetic at WIDTH+1 bits plus one guard bit, so negation of the most negative extended operand never overflows.
REQ-015 SHALL use the states IDLE, BUSY and DONE.
REQ-016 In IDLE: start=1 captures operands and mode, clears the accumulator and q-1, sets the iteration counter to 0, and moves to BUSY.
REQ-017 In BUSY: performs one iteration per cycle; after the iteration with counter = WIDTH, writes the low 2*WIDTH bits of the result to product and moves to DONE.
REQ-018 SHALL assert done exactly WIDTH+1 cycles after the edge that sampled start.
REQ-019 In DONE: done=1 for this single cycle; start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise moves to IDLE.
REQ-020 SHALL keep busy=1 in BUSY only; busy SHALL be 0 in IDLE and DONE.
REQ-021 SHALL ignore start while BUSY; the captured operands and mode SHALL be unaffected.
REQ-022 SHALL hold product stable from done until the cycle the next result is written; product SHALL NOT expose intermediate values.
REQ-023 SHALL treat operand changes while BUSY as having no effect.

Reset
REQ-024 On rst=1, SHALL immediately enter IDLE with busy=0, done=0, product=0, counter=0, and internal registers cleared, independent of clk.
REQ-025 A reset during BUSY SHALL abort the operation; no done pulse SHALL follow.
REQ-026 After rst deasserts, the first start seen on a rising edge SHALL begin a normal operation.

Structure
REQ-027 SHALL define the state enum (IDLE/BUSY/DONE) and the Booth-pair encoding constants in shared package booth_pkg.
REQ-028 SHALL place the combinational single-iteration add/subtract-and-shift datapath in sub-module booth_step, parametrised by WIDTH; seq_booth_multiplier holds the FSM, counter and registers.

Verification (WIDTH=8 unless stated)
REQ-029 Signed cases: signed_mode=1 with 3*1, -6*7, -2*-5 and -5*-5 SHALL give product 3, -42, 10 and 25, with done exactly 9 cycles after start.
REQ-030 Extremes: signed_mode=1 with -128*-128 SHALL give 16384; signed_mode=0 with 255*255 SHALL give 65025; signed_mode=0 with 128*2 SHALL give 256.
REQ-031 Start ignored: start pulsed again in BUSY cycle 4 with different operands SHALL leave the result of the first operation (-6*7 = -42) unchanged and produce a single done.
REQ-032 Back-to-back: start held high during the DONE cycle of 3*1 SHALL give done with 3, and the second operation (-2*-5) SHALL give done with 10 nine cycles later.
REQ-033 Reset mid-operation: rst asserted in BUSY cycle 5 SHALL set busy, done and product to 0 asynchronously with no done pulse; a following 7*7 SHALL give 49.
REQ-034 Parameter sweep: WIDTH=4 and WIDTH=16 with random signed and unsigned operands against a reference model SHALL match on every operation, with latency WIDTH+1.
